// File: rtl/arbitrate.sv
// ---------------------------------------------------------------------------
// arbitrate
//   Round-robin arbiter with an optional burst length. Shares one stb/rdy
//   sink between N stb/rdy requesters. Each accepted word is tagged with its
//   source index and presented as {index, data} from a registered output
//   stage: one cycle of latency, one word per cycle at full throughput.
//   A channel may win up to B consecutive transfers before the priority
//   pointer rotates past it, so no requester starves.
//
// Parameters
//   W  data width per channel
//   N  number of requesters (N >= 2, any value, not only powers of two)
//   B  max consecutive grants to one channel before rotation (B >= 1)
//
// Ports
//   clk    clock
//   rst    synchronous, active-high reset
//   s_stb  per-channel strobe
//   s_dat  per-channel data, channel i in bits [i*W +: W]
//   s_rdy  per-channel ready, at most one bit set (combinational)
//   m_rdy  downstream ready
//   m_stb  output valid
//   m_dat  {index, data}, index in the MSBs
// ---------------------------------------------------------------------------
module arbitrate #(
    parameter int W = 8,
    parameter int N = 2,
    parameter int B = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           s_stb,
    input  logic [N*W-1:0]         s_dat,
    output logic [N-1:0]           s_rdy,
    input  logic                   m_rdy,
    output logic                   m_stb,
    output logic [$clog2(N)+W-1:0] m_dat
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(B + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [CW-1:0] CMAX = CW'(B - 1);

    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] g;
    logic          any;
    logic          load;
    logic          xfer;
    logic [CW-1:0] c_eff;
    logic [W-1:0]  dat_sel;

    // Search ptr, ptr+1, ... with an explicit wrap at N-1 so that a
    // non-power-of-two N never lands on a nonexistent channel.
    always_comb begin : grant_search
        int            idx;
        logic [IW-1:0] cand;
        g    = ptr;
        any  = 1'b0;
        idx  = 0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IW'(idx);
            if (!any && s_stb[cand]) begin
                any = 1'b1;
                g   = cand;
            end
        end
    end

    assign load = ~m_stb | m_rdy;
    // The winner always has its strobe up, so a grant is a transfer.
    assign xfer = load & any & ~rst;

    always_comb begin
        s_rdy = '0;
        if (xfer) begin
            s_rdy[g] = 1'b1;
        end
    end

    // A grant that is not the current burst owner starts a fresh count;
    // this is what forfeits a burst when the owner drops its strobe.
    assign c_eff   = (g == ptr) ? cnt : '0;
    assign dat_sel = s_dat[int'(g)*W +: W];

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            m_stb <= 1'b0;
            m_dat <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            if (xfer) begin
                m_stb <= 1'b1;
                m_dat <= {g, dat_sel};
                if (c_eff == CMAX) begin
                    ptr <= (g == LAST) ? '0 : g + 1'b1;
                    cnt <= '0;
                end else begin
                    ptr <= g;
                    cnt <= c_eff + 1'b1;
                end
            end else if (m_stb & m_rdy) begin
                m_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arbitrate.sv
// ---------------------------------------------------------------------------
// tb_arbitrate
//   Three arbiter instances (N=4 B=1, N=4 B=2, N=3 B=2) driven one at a time
//   from a per-cycle vector table. Each row gives the inputs and the expected
//   s_rdy / m_stb (and optionally m_dat). A row that expects a grant pushes
//   the expected {index, data} word into a scoreboard queue; the queue is
//   popped whenever the active DUT shows m_stb & m_rdy.
// ---------------------------------------------------------------------------
module tb_arbitrate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dat_all = 32'h13121110;

    logic       rst_a, rst_b, rst_c;
    logic [3:0] stb_a, stb_b;
    logic [2:0] stb_c;
    logic       mrdy_a, mrdy_b, mrdy_c;
    logic [3:0] srdy_a, srdy_b;
    logic [2:0] srdy_c;
    logic       mstb_a, mstb_b, mstb_c;
    logic [9:0] mdat_a, mdat_b, mdat_c;

    arbitrate #(.W(8), .N(4), .B(1)) dut_a (
        .clk(clk), .rst(rst_a), .s_stb(stb_a), .s_dat(dat_all),
        .s_rdy(srdy_a), .m_rdy(mrdy_a), .m_stb(mstb_a), .m_dat(mdat_a)
    );

    arbitrate #(.W(8), .N(4), .B(2)) dut_b (
        .clk(clk), .rst(rst_b), .s_stb(stb_b), .s_dat(dat_all),
        .s_rdy(srdy_b), .m_rdy(mrdy_b), .m_stb(mstb_b), .m_dat(mdat_b)
    );

    arbitrate #(.W(8), .N(3), .B(2)) dut_c (
        .clk(clk), .rst(rst_c), .s_stb(stb_c), .s_dat(dat_all[23:0]),
        .s_rdy(srdy_c), .m_rdy(mrdy_c), .m_stb(mstb_c), .m_dat(mdat_c)
    );

    typedef struct {
        int         dut;
        logic       rst;
        logic [3:0] stb;
        logic       rdy;
        logic [3:0] e_rdy;
        logic       e_stb;
        logic       chk_dat;
        logic [9:0] e_dat;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] sb_q[$];
    int         passed = 0;
    int         total  = 0;

    task automatic add(input int d, input logic r, input logic [3:0] s,
                       input logic mr, input logic [3:0] er, input logic es,
                       input logic cd, input logic [9:0] ed);
        vec_t v;
        v.dut = d; v.rst = r; v.stb = s; v.rdy = mr;
        v.e_rdy = er; v.e_stb = es; v.chk_dat = cd; v.e_dat = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) r = k;
        end
        return r;
    endfunction

    initial begin
        vec_t       v;
        logic [3:0] o_rdy;
        logic       o_stb;
        logic [9:0] o_dat;
        logic [9:0] exp_w;
        logic [1:0] ix;
        logic [7:0] dd;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        stb_a = '0; stb_b = '0; stb_c = '0;
        mrdy_a = 1'b1; mrdy_b = 1'b1; mrdy_c = 1'b1;

        // N=4 B=1: reset, round-robin, backpressure on {2,0x12}, sparse/skip
        add(0, 1, 4'hF, 1, 4'h0, 0, 1, 10'h000);
        add(0, 1, 4'hF, 1, 4'h0, 0, 1, 10'h000);
        add(0, 0, 4'hF, 1, 4'h1, 0, 1, 10'h000);
        add(0, 0, 4'hF, 1, 4'h2, 1, 0, 10'h000);
        add(0, 0, 4'hF, 1, 4'h4, 1, 0, 10'h000);
        add(0, 0, 4'hF, 1, 4'h8, 1, 0, 10'h000);
        add(0, 0, 4'hF, 1, 4'h1, 1, 0, 10'h000);
        add(0, 0, 4'hF, 1, 4'h2, 1, 0, 10'h000);
        add(0, 0, 4'hF, 1, 4'h4, 1, 0, 10'h000);
        add(0, 0, 4'hF, 0, 4'h0, 1, 1, 10'h212);
        add(0, 0, 4'hF, 0, 4'h0, 1, 1, 10'h212);
        add(0, 0, 4'hF, 0, 4'h0, 1, 1, 10'h212);
        add(0, 0, 4'hF, 1, 4'h8, 1, 1, 10'h212);
        add(0, 0, 4'hF, 1, 4'h1, 1, 0, 10'h000);
        add(0, 0, 4'h0, 1, 4'h0, 1, 0, 10'h000);
        add(0, 0, 4'h4, 1, 4'h4, 0, 0, 10'h000);
        add(0, 0, 4'hA, 1, 4'h8, 1, 0, 10'h000);
        add(0, 0, 4'hA, 1, 4'h2, 1, 0, 10'h000);
        add(0, 0, 4'h0, 1, 4'h0, 1, 0, 10'h000);
        add(0, 0, 4'h0, 1, 4'h0, 0, 0, 10'h000);

        // N=4 B=2: bursts of two, then owner drop-out restarts the count
        add(1, 1, 4'hF, 1, 4'h0, 0, 1, 10'h000);
        add(1, 0, 4'hF, 1, 4'h1, 0, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h1, 1, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h2, 1, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h2, 1, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h4, 1, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h4, 1, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h8, 1, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h8, 1, 0, 10'h000);
        add(1, 0, 4'hF, 1, 4'h1, 1, 0, 10'h000);
        add(1, 0, 4'hE, 1, 4'h2, 1, 0, 10'h000);
        add(1, 0, 4'hE, 1, 4'h2, 1, 0, 10'h000);
        add(1, 0, 4'hE, 1, 4'h4, 1, 0, 10'h000);
        add(1, 0, 4'h0, 1, 4'h0, 1, 0, 10'h000);
        add(1, 0, 4'h0, 1, 4'h0, 0, 0, 10'h000);

        // N=3 B=2: wrap at N-1, then reset after the first word from ch1
        add(2, 1, 4'h7, 1, 4'h0, 0, 1, 10'h000);
        add(2, 0, 4'h7, 1, 4'h1, 0, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h1, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h2, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h2, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h4, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h4, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h1, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h1, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h2, 1, 0, 10'h000);
        add(2, 1, 4'h7, 1, 4'h0, 1, 1, 10'h111);
        add(2, 0, 4'h7, 1, 4'h1, 0, 1, 10'h000);
        add(2, 0, 4'h7, 1, 4'h1, 1, 0, 10'h000);
        add(2, 0, 4'h7, 1, 4'h2, 1, 0, 10'h000);
        add(2, 0, 4'h0, 1, 4'h0, 1, 0, 10'h000);
        add(2, 0, 4'h0, 1, 4'h0, 0, 0, 10'h000);

        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            #1;
            rst_a  = (v.dut == 0) ? v.rst : 1'b1;
            rst_b  = (v.dut == 1) ? v.rst : 1'b1;
            rst_c  = (v.dut == 2) ? v.rst : 1'b1;
            stb_a  = (v.dut == 0) ? v.stb : 4'h0;
            stb_b  = (v.dut == 1) ? v.stb : 4'h0;
            stb_c  = (v.dut == 2) ? v.stb[2:0] : 3'h0;
            mrdy_a = (v.dut == 0) ? v.rdy : 1'b1;
            mrdy_b = (v.dut == 1) ? v.rdy : 1'b1;
            mrdy_c = (v.dut == 2) ? v.rdy : 1'b1;

            @(negedge clk);
            case (v.dut)
                0:       begin o_rdy = srdy_a; o_stb = mstb_a; o_dat = mdat_a; end
                1:       begin o_rdy = srdy_b; o_stb = mstb_b; o_dat = mdat_b; end
                default: begin o_rdy = {1'b0, srdy_c}; o_stb = mstb_c; o_dat = mdat_c; end
            endcase

            check($sformatf("row%0d s_rdy", i), {28'h0, o_rdy}, {28'h0, v.e_rdy});
            check($sformatf("row%0d m_stb", i), {31'h0, o_stb}, {31'h0, v.e_stb});
            if (v.chk_dat) begin
                check($sformatf("row%0d m_dat", i), {22'h0, o_dat}, {22'h0, v.e_dat});
            end

            if (o_stb && v.rdy) begin
                if (sb_q.size() == 0) begin
                    total++;
                    $display("FAIL row%0d unexpected word: got %0h, want none", i, o_dat);
                end else begin
                    exp_w = sb_q.pop_front();
                    check($sformatf("row%0d sb word", i), {22'h0, o_dat}, {22'h0, exp_w});
                end
            end

            if (v.e_rdy != 4'h0) begin
                ix = 2'(onehot_idx(v.e_rdy));
                dd = 8'h10 + {6'h0, ix};
                sb_q.push_back({ix, dd});
            end

            @(posedge clk);
        end

        check("sb leftover words", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
